// File: rtl/pin_code_programmer.sv
// PIN code programmer: the user enters a new code and then confirms it, and the stored pinCode is replaced only when both entries match.
// Optional build macro PIN_PROG_TIMEOUT_EN enables the inter-key idle timeout.
module pin_code_programmer #(
  parameter int unsigned             DIGITS         = 4,
  parameter int unsigned             CODE_LENGTH    = 4 * DIGITS,
  parameter logic [CODE_LENGTH-1:0]  DEFAULT_CODE   = CODE_LENGTH'(16'h1248),
  parameter int unsigned             TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned             COUNTER_WIDTH  = $clog2(DIGITS + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [3:0]             key_i,
  input  logic                   unlocked_i,
  input  logic                   program_i,
  output logic [CODE_LENGTH-1:0] pin_code_o,
  output logic                   busy_o,
  output logic                   code_updated_o,
  output logic                   code_error_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ENTER   = 3'd1;
  localparam logic [2:0] CONFIRM = 3'd2;
  localparam logic [2:0] COMMIT  = 3'd3;
  localparam logic [2:0] ERROR   = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [CODE_LENGTH-1:0]   entry_q, entry_d;
  logic [CODE_LENGTH-1:0]   confirm_q, confirm_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [CODE_LENGTH-1:0]   pin_q, pin_d;
  logic                     busy_q, busy_d;
  logic                     upd_q, upd_d;
  logic                     err_q, err_d;

  logic key_valid;
  logic last_digit;
  logic abort;
  logic codes_match;
  logic timer_expired;

  assign key_valid   = $onehot(key_i);
  assign last_digit  = (cnt_q == COUNTER_WIDTH'(DIGITS - 1));
  assign abort       = !unlocked_i || program_i;
  assign codes_match = (entry_q == confirm_q);

`ifdef PIN_PROG_TIMEOUT_EN
  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TIMER_W-1:0] timer_q, timer_d;

  assign timer_expired = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Idle timer runs only while waiting in the same entry state; any key or transition restarts it.
  always_comb begin
    timer_d = '0;
    if ((state_q == ENTER || state_q == CONFIRM) && (state_d == state_q) && !key_valid) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timer_expired = 1'b0;
`endif

  // Next-state and datapath logic; abort beats key, and key beats timeout.
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    confirm_d = confirm_q;
    cnt_d     = cnt_q;
    pin_d     = pin_q;
    upd_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (program_i && unlocked_i) begin
          state_d = ENTER;
          entry_d = '0;
          cnt_d   = '0;
        end
      end

      ENTER: begin
        if (abort) begin
          state_d   = IDLE;
          entry_d   = '0;
          confirm_d = '0;
          cnt_d     = '0;
        end else if (key_valid) begin
          entry_d = {entry_q[CODE_LENGTH-5:0], key_i};
          if (last_digit) begin
            state_d   = CONFIRM;
            cnt_d     = '0;
            confirm_d = '0;
          end else begin
            cnt_d = cnt_q + COUNTER_WIDTH'(1);
          end
        end else if (timer_expired) begin
          state_d = ERROR;
        end
      end

      CONFIRM: begin
        if (abort) begin
          state_d   = IDLE;
          entry_d   = '0;
          confirm_d = '0;
          cnt_d     = '0;
        end else if (key_valid) begin
          confirm_d = {confirm_q[CODE_LENGTH-5:0], key_i};
          if (last_digit) begin
            state_d = COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + COUNTER_WIDTH'(1);
          end
        end else if (timer_expired) begin
          state_d = ERROR;
        end
      end

      COMMIT: begin
        if (codes_match) begin
          state_d   = IDLE;
          pin_d     = entry_q;
          upd_d     = 1'b1;
          entry_d   = '0;
          confirm_d = '0;
        end else begin
          state_d = ERROR;
        end
      end

      ERROR: begin
        state_d   = IDLE;
        entry_d   = '0;
        confirm_d = '0;
        cnt_d     = '0;
      end

      default: begin
        state_d   = IDLE;
        entry_d   = '0;
        confirm_d = '0;
        cnt_d     = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
    err_d  = (state_d == ERROR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      entry_q   <= '0;
      confirm_q <= '0;
      cnt_q     <= '0;
      pin_q     <= DEFAULT_CODE;
      busy_q    <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      confirm_q <= confirm_d;
      cnt_q     <= cnt_d;
      pin_q     <= pin_d;
      busy_q    <= busy_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
    end
  end

  assign pin_code_o     = pin_q;
  assign busy_o         = busy_q;
  assign code_updated_o = upd_q;
  assign code_error_o   = err_q;

endmodule

// File: tb/tb_pin_code_programmer.sv
// Directed bench for pin_code_programmer, with expected values worked out by hand.
module tb_pin_code_programmer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key;
  logic        unlocked;
  logic        prog;
  logic [15:0] pin_code;
  logic        busy;
  logic        code_updated;
  logic        code_error;

  int checks;
  int errors;

  pin_code_programmer #(
    .DIGITS(4),
    .CODE_LENGTH(16),
    .DEFAULT_CODE(16'h1248),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .key_i(key),
    .unlocked_i(unlocked),
    .program_i(prog),
    .pin_code_o(pin_code),
    .busy_o(busy),
    .code_updated_o(code_updated),
    .code_error_o(code_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key = k;
    tick();
    key = 4'b0000;
  endtask

  task automatic pulse_program();
    prog = 1'b1;
    tick();
    prog = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  int seen_at;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    key      = 4'b0000;
    unlocked = 1'b0;
    prog     = 1'b0;

    // Held in reset.
    repeat (3) tick();
    check("rst_pin", 32'(pin_code), 32'h1248);
    check("rst_busy", 32'(busy), 0);
    check("rst_upd", 32'(code_updated), 0);
    check("rst_err", 32'(code_error), 0);
    rst_n = 1'b1;
    tick();

    // Successful update to 2248.
    unlocked = 1'b1;
    pulse_program();
    check("enter_busy", 32'(busy), 1);
    enter4(4'b0010, 4'b0010, 4'b0100, 4'b1000);
    enter4(4'b0010, 4'b0010, 4'b0100, 4'b1000);
    check("ok_upd_n", 32'(code_updated), 0);
    check("ok_pin_n", 32'(pin_code), 32'h1248);
    tick();
    check("ok_upd_n1", 32'(code_updated), 1);
    check("ok_pin_n1", 32'(pin_code), 32'h2248);
    tick();
    check("ok_upd_n2", 32'(code_updated), 0);
    check("ok_busy_n2", 32'(busy), 0);

    // Mismatch: 2248 then 2241.
    pulse_program();
    enter4(4'b0010, 4'b0010, 4'b0100, 4'b1000);
    enter4(4'b0010, 4'b0010, 4'b0100, 4'b0001);
    check("mm_err_n", 32'(code_error), 0);
    tick();
    check("mm_err_n1", 32'(code_error), 1);
    check("mm_upd_n1", 32'(code_updated), 0);
    tick();
    check("mm_err_n2", 32'(code_error), 0);
    check("mm_busy_n2", 32'(busy), 0);
    check("mm_pin", 32'(pin_code), 32'h2248);

    // Program request while locked is ignored.
    unlocked = 1'b0;
    pulse_program();
    tick();
    check("locked_busy", 32'(busy), 0);
    unlocked = 1'b1;

    // Multi-hot and zero keys are ignored during entry.
    pulse_program();
    press(4'b1000);
    press(4'b0011);
    press(4'b0000);
    press(4'b0100);
    press(4'b0010);
    check("mh_busy", 32'(busy), 1);
    press(4'b0001);
    enter4(4'b1000, 4'b0100, 4'b0010, 4'b0001);
    tick();
    check("mh_upd", 32'(code_updated), 1);
    check("mh_pin", 32'(pin_code), 32'h8421);
    tick();

    // Dropping unlocked in the middle of CONFIRM aborts without a pulse.
    pulse_program();
    enter4(4'b0001, 4'b0001, 4'b0001, 4'b0001);
    press(4'b0001);
    press(4'b0001);
    unlocked = 1'b0;
    key = 4'b0001;
    tick();
    key = 4'b0000;
    check("abort_busy", 32'(busy), 0);
    check("abort_err", 32'(code_error), 0);
    check("abort_upd", 32'(code_updated), 0);
    unlocked = 1'b1;
    tick();
    check("abort_pin", 32'(pin_code), 32'h8421);

    // A program pulse during ENTER aborts, even when a key arrives in the same cycle.
    pulse_program();
    press(4'b0010);
    prog = 1'b1;
    key  = 4'b0100;
    tick();
    prog = 1'b0;
    key  = 4'b0000;
    check("prog_abort_busy", 32'(busy), 0);

    // Idle timeout after two digits.
    pulse_program();
    press(4'b0010);
    press(4'b0010);
    seen_at = 0;
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (code_error && seen_at == 0) seen_at = i;
    end
`ifdef PIN_PROG_TIMEOUT_EN
    check("to_err_cycle", 32'(seen_at), 100);
    check("to_busy", 32'(busy), 0);
`else
    check("to_no_err", 32'(seen_at), 0);
    check("to_still_busy", 32'(busy), 1);
    pulse_program();
    check("to_abort_busy", 32'(busy), 0);
`endif
    check("to_pin", 32'(pin_code), 32'h8421);

    // Asynchronous reset in the middle of CONFIRM restores the default code.
    tick();
    pulse_program();
    enter4(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    press(4'b0001);
    press(4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pin", 32'(pin_code), 32'h1248);
    check("midrst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
